// File: rtl/exception_sequencer.sv
// ---------------------------------------------------------------------------
// exception_sequencer
//
// Multi-cycle exception entry / return-from-exception sequencer for the
// multi-cycle MIPS core. Collects NUM_CAUSES prioritised, maskable exception
// requests into sticky pending bits. Services one cause per entry sequence:
// it saves the faulting PC into epc, reads a one-byte handler address from
// the vector table at VEC_BASE + cause, and loads that byte into the PC.
// An rte request reloads the PC from epc.
//
// Ports:
//   clk        - clock
//   reset      - synchronous, active-high reset
//   cause_req  - per-cause request, ORed into pending every edge
//   cause_mask - 1 = cause blocked from service (stays pending)
//   pc_in      - address of the faulting instruction
//   rte        - single-cycle return-from-exception request
//   mem_rdata  - memory byte returned for the vector read
//   busy       - high whenever the sequencer is not idle
//   mem_req    - memory read strobe (vector fetch)
//   mem_addr   - vector-table address, 0 outside the fetch
//   pc_load    - one-cycle PC write strobe
//   pc_value   - value to write into PC, 0 when not loading
//   epc        - saved exception PC
//   cause_code - index of the last serviced cause
//   ack        - one-cycle pulse after a cause is accepted
// ---------------------------------------------------------------------------
module exception_sequencer #(
  parameter int NUM_CAUSES = 4,
  parameter int ADDR_W     = 32,
  parameter int VEC_BASE   = 253,
  parameter int MEM_LAT    = 1,
  localparam int CW        = (NUM_CAUSES > 1) ? $clog2(NUM_CAUSES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CAUSES-1:0] cause_req,
  input  logic [NUM_CAUSES-1:0] cause_mask,
  input  logic [ADDR_W-1:0]     pc_in,
  input  logic                  rte,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  pc_load,
  output logic [ADDR_W-1:0]     pc_value,
  output logic [ADDR_W-1:0]     epc,
  output logic [CW-1:0]         cause_code,
  output logic                  ack
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_RET  = 2'd3;

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [1:0]            state;
  logic [NUM_CAUSES-1:0] pending;
  logic [NUM_CAUSES-1:0] pend_nx;
  logic [NUM_CAUSES-1:0] eligible;
  logic [NUM_CAUSES-1:0] clr_bit;
  logic [CNT_W-1:0]      counter;
  logic [CW-1:0]         sel;
  logic                  any_eligible;

  // New requests are folded in before arbitration, so a request that
  // arrives in the same cycle as an idle sequencer is serviced at once.
  assign pend_nx  = pending | cause_req;
  assign eligible = pend_nx & ~cause_mask;

  // Lowest-index eligible cause wins; scanning downward leaves the lowest
  // index as the last assignment.
  always_comb begin
    sel          = '0;
    any_eligible = 1'b0;
    for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel          = CW'(i);
        any_eligible = 1'b1;
      end
    end
    clr_bit      = '0;
    clr_bit[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pending    <= '0;
      epc        <= '0;
      cause_code <= '0;
      counter    <= '0;
      ack        <= 1'b0;
    end else begin
      ack     <= 1'b0;
      pending <= pend_nx;
      case (state)
        ST_IDLE: begin
          // A cause beats a simultaneous rte; that rte is dropped.
          if (any_eligible) begin
            epc        <= pc_in;
            cause_code <= sel;
            pending    <= pend_nx & ~clr_bit;
            counter    <= CNT_W'(MEM_LAT - 1);
            state      <= ST_READ;
            ack        <= 1'b1;
          end else if (rte) begin
            state <= ST_RET;
          end
        end
        ST_READ: begin
          // Counter starts at MEM_LAT-1, so READ lasts exactly MEM_LAT cycles.
          if (counter == '0) begin
            state <= ST_LOAD;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        ST_LOAD: state <= ST_IDLE;
        ST_RET:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore outputs decoded purely from state; data buses are zero when idle.
  always_comb begin
    busy     = (state != ST_IDLE);
    mem_req  = (state == ST_READ);
    pc_load  = (state == ST_LOAD) || (state == ST_RET);
    mem_addr = '0;
    pc_value = '0;
    if (state == ST_READ) begin
      mem_addr = ADDR_W'(VEC_BASE) + ADDR_W'(cause_code);
    end
    if (state == ST_LOAD) begin
      pc_value = ADDR_W'(mem_rdata);
    end else if (state == ST_RET) begin
      pc_value = epc;
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exception_sequencer
//
// Directed self-checking bench. Instance dut uses MEM_LAT = 1 and covers
// reset, single cause, priority, masking, busy accumulation, rte and
// mid-sequence reset. Instance dut3 uses MEM_LAT = 3 to cover the latency
// parameter. Inputs are driven and outputs sampled 1 time unit after each
// rising edge.
// ---------------------------------------------------------------------------
module tb_exception_sequencer;

  logic        clk;
  logic        reset;

  logic [3:0]  cause_req;
  logic [3:0]  cause_mask;
  logic [31:0] pc_in;
  logic        rte;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        pc_load;
  logic [31:0] pc_value;
  logic [31:0] epc;
  logic [1:0]  cause_code;
  logic        ack;

  logic [3:0]  cause_req3;
  logic [3:0]  cause_mask3;
  logic [31:0] pc_in3;
  logic        rte3;
  logic [7:0]  mem_rdata3;
  logic        busy3;
  logic        mem_req3;
  logic [31:0] mem_addr3;
  logic        pc_load3;
  logic [31:0] pc_value3;
  logic [31:0] epc3;
  logic [1:0]  cause_code3;
  logic        ack3;

  int checks;
  int errors;

  exception_sequencer #(.NUM_CAUSES(4), .ADDR_W(32), .VEC_BASE(253), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset), .cause_req(cause_req), .cause_mask(cause_mask),
    .pc_in(pc_in), .rte(rte), .mem_rdata(mem_rdata), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .pc_load(pc_load),
    .pc_value(pc_value), .epc(epc), .cause_code(cause_code), .ack(ack)
  );

  exception_sequencer #(.NUM_CAUSES(4), .ADDR_W(32), .VEC_BASE(253), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .cause_req(cause_req3), .cause_mask(cause_mask3),
    .pc_in(pc_in3), .rte(rte3), .mem_rdata(mem_rdata3), .busy(busy3),
    .mem_req(mem_req3), .mem_addr(mem_addr3), .pc_load(pc_load3),
    .pc_value(pc_value3), .epc(epc3), .cause_code(cause_code3), .ack(ack3)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Directed sequence; each check reflects the state entered at the last edge.
  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    cause_req   = '0;
    cause_mask  = '0;
    pc_in       = '0;
    rte         = 1'b0;
    mem_rdata   = '0;
    cause_req3  = '0;
    cause_mask3 = '0;
    pc_in3      = '0;
    rte3        = 1'b0;
    mem_rdata3  = '0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_pc_load", pc_load, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_epc", epc, 0);
    checkOutput("rst_cause_code", cause_code, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_pc_value", pc_value, 0);
    reset = 1'b0;
    tick();

    // Single cause 2, vector byte 0x7C
    cause_req = 4'b0100;
    pc_in     = 32'h40;
    mem_rdata = 8'h7C;
    tick();
    cause_req = '0;
    checkOutput("single_ack", ack, 1);
    checkOutput("single_busy_read", busy, 1);
    checkOutput("single_mem_req", mem_req, 1);
    checkOutput("single_mem_addr", mem_addr, 255);
    checkOutput("single_no_load_yet", pc_load, 0);
    checkOutput("single_epc", epc, 32'h40);
    checkOutput("single_cause_code", cause_code, 2);
    tick();
    checkOutput("single_ack_pulse", ack, 0);
    checkOutput("single_mem_req_off", mem_req, 0);
    checkOutput("single_mem_addr_zero", mem_addr, 0);
    checkOutput("single_pc_load", pc_load, 1);
    checkOutput("single_pc_value", pc_value, 32'h7C);
    checkOutput("single_busy_load", busy, 1);
    tick();
    checkOutput("single_idle_busy", busy, 0);
    checkOutput("single_idle_pc_load", pc_load, 0);
    checkOutput("single_idle_pc_value", pc_value, 0);

    // Priority: causes 1 and 2 together, 1 first
    cause_req = 4'b0110;
    tick();
    cause_req = '0;
    checkOutput("prio_first_addr", mem_addr, 254);
    checkOutput("prio_first_code", cause_code, 1);
    tick();
    checkOutput("prio_first_load", pc_load, 1);
    tick();
    checkOutput("prio_gap_idle", busy, 0);
    tick();
    checkOutput("prio_second_ack", ack, 1);
    checkOutput("prio_second_addr", mem_addr, 255);
    checkOutput("prio_second_code", cause_code, 2);
    tick();
    checkOutput("prio_second_load", pc_load, 1);
    tick();
    checkOutput("prio_done_idle", busy, 0);

    // Masking: cause 0 held pending while masked for 5 cycles
    cause_mask = 4'b0001;
    cause_req  = 4'b0001;
    tick();
    cause_req = '0;
    checkOutput("mask_no_ack", ack, 0);
    checkOutput("mask_no_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("mask_still_idle", busy, 0);
    end
    cause_mask = '0;
    tick();
    checkOutput("unmask_ack", ack, 1);
    checkOutput("unmask_mem_addr", mem_addr, 253);
    checkOutput("unmask_code", cause_code, 0);
    tick();
    tick();
    checkOutput("unmask_done_idle", busy, 0);

    // Busy accumulation: cause 3 arrives while cause 0 is in READ
    cause_req = 4'b0001;
    pc_in     = 32'h10;
    tick();
    checkOutput("accum_c0_epc", epc, 32'h10);
    cause_req = 4'b1000;
    pc_in     = 32'h40;
    tick();
    cause_req = '0;
    checkOutput("accum_c0_load", pc_load, 1);
    tick();
    checkOutput("accum_gap_idle", busy, 0);
    tick();
    checkOutput("accum_c3_ack", ack, 1);
    checkOutput("accum_c3_addr", mem_addr, 256);
    checkOutput("accum_c3_code", cause_code, 3);
    checkOutput("accum_c3_epc", epc, 32'h40);
    tick();
    tick();
    checkOutput("accum_done_idle", busy, 0);

    // RTE returns to saved epc
    rte   = 1'b1;
    pc_in = 32'h99;
    tick();
    rte = 1'b0;
    checkOutput("rte_pc_load", pc_load, 1);
    checkOutput("rte_pc_value", pc_value, 32'h40);
    checkOutput("rte_busy", busy, 1);
    checkOutput("rte_no_mem_req", mem_req, 0);
    checkOutput("rte_no_ack", ack, 0);
    tick();
    checkOutput("rte_done_pc_load", pc_load, 0);
    checkOutput("rte_done_busy", busy, 0);

    // Cause beats simultaneous rte; the rte is dropped
    cause_req = 4'b0010;
    rte       = 1'b1;
    pc_in     = 32'h24;
    tick();
    cause_req = '0;
    rte       = 1'b0;
    checkOutput("race_mem_req", mem_req, 1);
    checkOutput("race_code", cause_code, 1);
    tick();
    checkOutput("race_load_vec", pc_value, 32'h7C);
    tick();
    checkOutput("race_rte_dropped", pc_load, 0);
    checkOutput("race_idle", busy, 0);

    // Reset during READ aborts sequence and clears pending cause 2
    cause_req = 4'b0110;
    pc_in     = 32'h55;
    tick();
    cause_req = '0;
    checkOutput("abort_in_read", mem_req, 1);
    reset = 1'b1;
    tick();
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_mem_req", mem_req, 0);
    checkOutput("abort_pc_load", pc_load, 0);
    checkOutput("abort_epc", epc, 0);
    checkOutput("abort_ack", ack, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("abort_no_load", pc_load, 0);
      checkOutput("abort_pending_clear", busy, 0);
    end

    // MEM_LAT = 3: three READ cycles, byte sampled in LOAD cycle
    cause_req3 = 4'b0001;
    pc_in3     = 32'h20;
    mem_rdata3 = 8'h11;
    tick();
    cause_req3 = '0;
    checkOutput("lat3_ack", ack3, 1);
    checkOutput("lat3_req_c1", mem_req3, 1);
    checkOutput("lat3_addr", mem_addr3, 253);
    tick();
    checkOutput("lat3_req_c2", mem_req3, 1);
    checkOutput("lat3_no_load_c2", pc_load3, 0);
    tick();
    checkOutput("lat3_req_c3", mem_req3, 1);
    checkOutput("lat3_no_load_c3", pc_load3, 0);
    mem_rdata3 = 8'hA5;
    tick();
    checkOutput("lat3_req_off", mem_req3, 0);
    checkOutput("lat3_pc_load", pc_load3, 1);
    checkOutput("lat3_pc_value", pc_value3, 32'hA5);
    checkOutput("lat3_epc", epc3, 32'h20);
    tick();
    checkOutput("lat3_idle", busy3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
